// File: rtl/sram_dual_port_be.sv
// Dual-port word RAM with per-byte write enables and a self-zeroing clear FSM.
// Port A has byte priority over port B when both write the same word in one cycle.
module sram_dual_port_be #(
    parameter int RAM_WIDTH     = 32,
    parameter int RAM_ADDR_BITS = 10,
    parameter int RDW_MODE      = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    output logic                     ready_o,
    input  logic                     en_A,
    input  logic                     en_B,
    input  logic                     we_A,
    input  logic                     we_B,
    input  logic [RAM_WIDTH/8-1:0]   be_A,
    input  logic [RAM_WIDTH/8-1:0]   be_B,
    input  logic [RAM_ADDR_BITS-1:0] addr_A,
    input  logic [RAM_ADDR_BITS-1:0] addr_B,
    input  logic [RAM_WIDTH-1:0]     data_iA,
    input  logic [RAM_WIDTH-1:0]     data_iB,
    output logic [RAM_WIDTH-1:0]     data_oA,
    output logic [RAM_WIDTH-1:0]     data_oB,
    output logic                     valid_oA,
    output logic                     valid_oB,
    output logic                     collision_o
);

    localparam int NB    = RAM_WIDTH / 8;
    localparam int DEPTH = 2 ** RAM_ADDR_BITS;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] clr_cnt_q, clr_cnt_d;

    logic [RAM_WIDTH-1:0] mem_q [DEPTH];

    logic                 acc_a, acc_b;
    logic                 wr_a, wr_b;
    logic                 same_wr;
    logic [RAM_WIDTH-1:0] mask_a, mask_b;
    logic [RAM_WIDTH-1:0] old_a, old_b;
    logic [RAM_WIDTH-1:0] merged_a, merged_b;
    logic [RAM_WIDTH-1:0] both_word;
    logic [RAM_WIDTH-1:0] rdata_a, rdata_b;

    logic [RAM_WIDTH-1:0] data_a_q, data_a_d;
    logic [RAM_WIDTH-1:0] data_b_q, data_b_d;
    logic                 valid_a_q, valid_b_q;
    logic                 coll_q;

    assign ready_o = (state_q == READY);

    // Next-state logic: sweep the array in CLEAR, re-enter CLEAR on request
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            CLEAR: begin
                clr_cnt_d = clr_cnt_q + RAM_ADDR_BITS'(1);
                if (clr_cnt_q == {RAM_ADDR_BITS{1'b1}}) begin
                    state_d   = READY;
                    clr_cnt_d = '0;
                end
            end
            READY: begin
                if (clear_i) begin
                    state_d   = CLEAR;
                    clr_cnt_d = '0;
                end
            end
        endcase
    end

    // State and sweep counter registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Expand byte enables to bit masks
    always_comb begin
        mask_a = '0;
        mask_b = '0;
        for (int k = 0; k < NB; k++) begin
            mask_a[8*k +: 8] = {8{be_A[k]}};
            mask_b[8*k +: 8] = {8{be_B[k]}};
        end
    end

    // Port qualification and write-merge datapath
    always_comb begin
        acc_a    = ready_o & en_A & ~rst_i;
        acc_b    = ready_o & en_B & ~rst_i;
        wr_a     = acc_a & we_A;
        wr_b     = acc_b & we_B;
        same_wr  = wr_a & wr_b & (addr_A == addr_B);
        old_a    = mem_q[addr_A];
        old_b    = mem_q[addr_B];
        merged_a = (old_a & ~mask_a) | (data_iA & mask_a);
        merged_b = (old_b & ~mask_b) | (data_iB & mask_b);
        // B's merge first, then A's bytes on top: A wins shared bytes
        both_word = (merged_b & ~mask_a) | (data_iA & mask_a);
        rdata_a  = old_a;
        rdata_b  = old_b;
        if (RDW_MODE == 0) begin
            if (we_A) rdata_a = merged_a;
            if (we_B) rdata_b = merged_b;
        end
    end

    // Array writes: zero sweep while clearing, port writes when ready
    always_ff @(posedge clk_i) begin
        if (!ready_o) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (same_wr) begin
            mem_q[addr_A] <= both_word;
        end else begin
            if (wr_a) mem_q[addr_A] <= merged_a;
            if (wr_b) mem_q[addr_B] <= merged_b;
        end
    end

    // Read data holds when its port is idle
    always_comb begin
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        if (acc_a) data_a_d = rdata_a;
        if (acc_b) data_b_d = rdata_b;
    end

    // Output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_a_q  <= '0;
            data_b_q  <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
            coll_q    <= 1'b0;
        end else begin
            data_a_q  <= data_a_d;
            data_b_q  <= data_b_d;
            valid_a_q <= acc_a;
            valid_b_q <= acc_b;
            coll_q    <= same_wr;
        end
    end

    assign data_oA     = data_a_q;
    assign data_oB     = data_b_q;
    assign valid_oA    = valid_a_q;
    assign valid_oB    = valid_b_q;
    assign collision_o = coll_q;

endmodule

// File: tb/tb_sram_dual_port_be.sv
// Bench for sram_dual_port_be: write-first and read-first copies share stimulus.
// A word-array model with a clear countdown predicts every output.
module tb_sram_dual_port_be;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr;
    logic        enA, enB, weA, weB;
    logic [3:0]  beA, beB, aA, aB;
    logic [31:0] dA, dB;

    logic        rdy0, rdy1, vA0, vA1, vB0, vB1, col0, col1;
    logic [31:0] oA0, oA1, oB0, oB1;

    sram_dual_port_be #(
        .RAM_WIDTH(32), .RAM_ADDR_BITS(4), .RDW_MODE(0)
    ) u_wf (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .ready_o(rdy0),
        .en_A(enA), .en_B(enB), .we_A(weA), .we_B(weB),
        .be_A(beA), .be_B(beB), .addr_A(aA), .addr_B(aB),
        .data_iA(dA), .data_iB(dB), .data_oA(oA0), .data_oB(oB0),
        .valid_oA(vA0), .valid_oB(vB0), .collision_o(col0)
    );

    sram_dual_port_be #(
        .RAM_WIDTH(32), .RAM_ADDR_BITS(4), .RDW_MODE(1)
    ) u_rf (
        .clk_i(clk), .rst_i(rst), .clear_i(clr), .ready_o(rdy1),
        .en_A(enA), .en_B(enB), .we_A(weA), .we_B(weB),
        .be_A(beA), .be_B(beB), .addr_A(aA), .addr_B(aB),
        .data_iA(dA), .data_iB(dB), .data_oA(oA1), .data_oB(oB1),
        .valid_oA(vA1), .valid_oB(vB1), .collision_o(col1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Model state
    logic [31:0] mdl [16];
    int          clear_left = 16;
    logic        e_vA, e_vB, e_col;
    logic [31:0] e_a0, e_a1, e_b0, e_b1;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] nw,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    task automatic tick();
        logic [31:0] oldA, oldB;
        if (rst) begin
            clear_left = 16;
            e_vA = 0; e_vB = 0; e_col = 0;
            e_a0 = 0; e_a1 = 0; e_b0 = 0; e_b1 = 0;
        end else if (clear_left > 0) begin
            clear_left--;
            e_vA = 0; e_vB = 0; e_col = 0;
            if (clear_left == 0)
                for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        end else begin
            oldA = mdl[aA];
            oldB = mdl[aB];
            e_vA = enA;
            e_vB = enB;
            if (enA) begin
                e_a0 = weA ? merge(oldA, dA, beA) : oldA;
                e_a1 = oldA;
            end
            if (enB) begin
                e_b0 = weB ? merge(oldB, dB, beB) : oldB;
                e_b1 = oldB;
            end
            e_col = enA && enB && weA && weB && (aA == aB);
            if (enB && weB) mdl[aB] = merge(mdl[aB], dB, beB);
            if (enA && weA) mdl[aA] = merge(mdl[aA], dA, beA);
            if (clr) clear_left = 16;
        end
        @(posedge clk);
        #1;
        check("ready_wf", {31'b0, rdy0}, {31'b0, clear_left == 0});
        check("ready_rf", {31'b0, rdy1}, {31'b0, clear_left == 0});
        check("validA_wf", {31'b0, vA0}, {31'b0, e_vA});
        check("validA_rf", {31'b0, vA1}, {31'b0, e_vA});
        check("validB_wf", {31'b0, vB0}, {31'b0, e_vB});
        check("validB_rf", {31'b0, vB1}, {31'b0, e_vB});
        check("coll_wf", {31'b0, col0}, {31'b0, e_col});
        check("coll_rf", {31'b0, col1}, {31'b0, e_col});
        check("dataA_wf", oA0, e_a0);
        check("dataA_rf", oA1, e_a1);
        check("dataB_wf", oB0, e_b0);
        check("dataB_rf", oB1, e_b1);
    endtask

    task automatic set_a(input logic en, input logic we, input logic [3:0] be,
                         input logic [3:0] a, input logic [31:0] d);
        enA = en; weA = we; beA = be; aA = a; dA = d;
    endtask

    task automatic set_b(input logic en, input logic we, input logic [3:0] be,
                         input logic [3:0] a, input logic [31:0] d);
        enB = en; weB = we; beB = be; aB = a; dB = d;
    endtask

    task automatic idle();
        set_a(0, 0, 4'h0, 4'h0, 32'h0);
        set_b(0, 0, 4'h0, 4'h0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        e_vA = 0; e_vB = 0; e_col = 0;
        e_a0 = 0; e_a1 = 0; e_b0 = 0; e_b1 = 0;
        rst = 1; clr = 0;
        idle();
        tick();
        tick();
        rst = 0;
        repeat (16) tick();
        check("ready_after16", {31'b0, rdy0}, 32'h1);

        // Every word reads zero after the power-up sweep
        for (int i = 0; i < 16; i++) begin
            set_a(1, 0, 4'h0, 4'(i), 32'h0);
            tick();
        end
        idle();
        tick();

        // Partial write with read-during-write on port A
        set_a(1, 1, 4'hF, 4'd3, 32'h11223344);
        tick();
        set_a(1, 1, 4'h5, 4'd3, 32'hAABBCCDD);
        tick();
        check("rdw_wf", oA0, 32'h11BB33DD);
        check("rdw_rf", oA1, 32'h11223344);
        set_a(1, 0, 4'h0, 4'd3, 32'h0);
        tick();
        check("rd3", oA0, 32'h11BB33DD);

        // Same-address write/write: A high bytes, B low bytes
        set_a(1, 1, 4'hC, 4'd7, 32'hFFFF0000);
        set_b(1, 1, 4'hF, 4'd7, 32'h0000FFFF);
        tick();
        check("coll_pulse", {31'b0, col0}, 32'h1);
        idle();
        tick();
        set_a(1, 0, 4'h0, 4'd7, 32'h0);
        tick();
        check("ram7", oA0, 32'hFFFFFFFF);

        // Cross-port read sees the old word
        set_a(1, 1, 4'hF, 4'd2, 32'hCAFEBABE);
        set_b(1, 0, 4'h0, 4'd2, 32'h0);
        tick();
        check("xport_old", oB0, 32'h0);
        idle();
        set_b(1, 0, 4'h0, 4'd2, 32'h0);
        tick();
        check("xport_new", oB0, 32'hCAFEBABE);

        // Fill, clear, attempt writes during the sweep, read back
        idle();
        for (int i = 0; i < 16; i++) begin
            set_a(1, 1, 4'hF, 4'(i), $urandom);
            tick();
        end
        idle();
        clr = 1;
        tick();
        clr = 0;
        for (int i = 0; i < 16; i++) begin
            set_a(1, 1, 4'hF, 4'(i), 32'hDEADBEEF);
            tick();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            set_a(1, 0, 4'h0, 4'(i), 32'h0);
            tick();
        end

        // Reset in the middle of a sweep restarts it
        set_a(1, 1, 4'hF, 4'd5, 32'h5A5A5A5A);
        tick();
        rst = 1;
        idle();
        tick();
        rst = 0;
        repeat (9) tick();
        rst = 1;
        tick();
        rst = 0;
        repeat (15) tick();
        check("ready_low15", {31'b0, rdy0}, 32'h0);
        tick();
        check("ready_high16", {31'b0, rdy0}, 32'h1);

        // Randomized traffic, biased toward a few addresses
        for (int n = 0; n < 900; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            clr = ($urandom_range(0, 79) == 0);
            set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  4'($urandom), 4'($urandom_range(0, 1) ? $urandom_range(0, 3)
                                                       : $urandom_range(0, 15)),
                  $urandom);
            set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  4'($urandom), 4'($urandom_range(0, 1) ? $urandom_range(0, 3)
                                                       : $urandom_range(0, 15)),
                  $urandom);
            tick();
        end
        rst = 0;
        clr = 0;
        idle();
        repeat (17) tick();
        for (int i = 0; i < 16; i++) begin
            set_a(1, 0, 4'h0, 4'(i), 32'h0);
            set_b(1, 0, 4'h0, 4'(15 - i), 32'h0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
